freq_div_counter: RTL

Programmable divide-by-2N counter stage of the frequency divider. It runs a 4-bit count against an active divisor and toggles a 50%-duty divided clock at every terminal count. It presents its running count and active divisor as the A and B operands of the downstream 4-bit comparator, which is enabled with C3 tied high. It also accepts divisor updates through a load/acknowledge handshake that takes effect only on a period boundary.

---
 rtl/freq_div_counter_if.sv | 25 ++
 rtl/freq_div_counter.sv | 100 ++++++++++
 2 files changed

// File: rtl/freq_div_counter_if.sv
// Control and status bundle between the divider sequencer and the divide-by-2N counter stage.
// The counter stage presents count/div_b as the A/B operands of the downstream comparator.
interface freq_div_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] div_n;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] div_b;
    logic             tc;
    logic             clk_out;
    logic             load_ack;
    logic             pending;

    modport master (
        output en, load, div_n,
        input  count, div_b, tc, clk_out, load_ack, pending
    );

    modport slave (
        input  en, load, div_n,
        output count, div_b, tc, clk_out, load_ack, pending
    );
endinterface

// File: rtl/freq_div_counter.sv
// Programmable divide-by-2N counter stage: 4-bit count against an active divisor, 50% duty
// divided clock, and a load/acknowledge handshake that swaps the divisor on a period boundary.
module freq_div_counter #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    freq_div_counter_if.slave   bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]       state_q,    state_d;
    logic [WIDTH-1:0] count_q,    count_d;
    logic [WIDTH-1:0] div_b_q,    div_b_d;
    logic [WIDTH-1:0] pend_val_q, pend_val_d;
    logic             clk_out_q,  clk_out_d;
    logic             load_ack_q, load_ack_d;
    logic             pending_q,  pending_d;

    logic [WIDTH-1:0] div_b_m1;
    logic             tc;
    logic             apply;
    logic [WIDTH-1:0] apply_val;

    assign div_b_m1 = div_b_q - ONE;
    assign tc       = (state_q == RUN) && bus.en && (count_q == div_b_m1);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        div_b_d    = div_b_q;
        pend_val_d = pend_val_q;
        clk_out_d  = clk_out_q;
        load_ack_d = 1'b0;
        pending_d  = pending_q;
        apply      = 1'b0;
        apply_val  = bus.load ? bus.div_n : pend_val_q;

        // A fresh load takes priority over the stored value; blocking while load_ack_q is high
        // keeps the acknowledge from ever lasting two cycles.
        if (state_q == IDLE) begin
            apply = (bus.load || pending_q) && !load_ack_q;
        end else if (tc) begin
            count_d   = '0;
            clk_out_d = ~clk_out_q;
            apply     = (bus.load || pending_q) && !load_ack_q;
        end else if (bus.en) begin
            count_d = count_q + ONE;
        end

        if (apply) begin
            div_b_d    = apply_val;
            count_d    = '0;
            pending_d  = 1'b0;
            load_ack_d = 1'b1;
            if (apply_val == '0) begin
                state_d   = IDLE;
                clk_out_d = 1'b0;
            end else begin
                state_d = RUN;
                if (state_q == IDLE) begin
                    clk_out_d = 1'b0;
                end
            end
        end else if (bus.load) begin
            pending_d  = 1'b1;
            pend_val_d = bus.div_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            div_b_q    <= '0;
            pend_val_q <= '0;
            clk_out_q  <= 1'b0;
            load_ack_q <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            div_b_q    <= div_b_d;
            pend_val_q <= pend_val_d;
            clk_out_q  <= clk_out_d;
            load_ack_q <= load_ack_d;
            pending_q  <= pending_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.div_b    = div_b_q;
    assign bus.tc       = tc;
    assign bus.clk_out  = clk_out_q;
    assign bus.load_ack = load_ack_q;
    assign bus.pending  = pending_q;
endmodule
